// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the ROM address and fills the
// IF/ID register, choosing the next PC from branch/stall/jr/jump/sequential.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter logic [31:0] NOP_WORD = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instruction,
  input  logic        Stall,
  input  logic        Branch_taken,
  input  logic [31:0] Branch_target,
  input  logic        Jump,
  input  logic [25:0] Jump_index,
  input  logic        JR,
  input  logic [31:0] JR_target,
  output logic [31:0] PC,
  output logic [31:0] IFID_Instruction,
  output logic [31:0] IFID_PC_plus_4,
  output logic        IFID_Valid
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic        ifid_valid_q, ifid_valid_d;

  logic [31:0] pc_plus_4;
  logic [31:0] jump_target;
  logic        flush;

  assign pc_plus_4   = pc_q + 32'd4;
  assign jump_target = {ifid_pc4_q[31:28], Jump_index, 2'b00};

  always_comb begin
    pc_d         = pc_plus_4;
    ifid_instr_d = Instruction;
    ifid_pc4_d   = pc_plus_4;
    ifid_valid_d = 1'b1;
    flush        = 1'b0;
    // Taken branch outranks stall: whatever sits in ID is wrong-path anyway.
    if (Branch_taken) begin
      pc_d  = Branch_target;
      flush = 1'b1;
    end else if (Stall) begin
      pc_d         = pc_q;
      ifid_instr_d = ifid_instr_q;
      ifid_pc4_d   = ifid_pc4_q;
      ifid_valid_d = ifid_valid_q;
    end else if (JR) begin
      pc_d  = JR_target;
      flush = 1'b1;
    end else if (Jump) begin
      pc_d  = jump_target;
      flush = 1'b1;
    end
    // No delay slot: the word fetched behind a redirect becomes a bubble.
    if (flush) begin
      ifid_instr_d = NOP_WORD;
      ifid_pc4_d   = 32'd0;
      ifid_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q         <= RESET_PC;
      ifid_instr_q <= NOP_WORD;
      ifid_pc4_q   <= 32'd0;
      ifid_valid_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  assign PC               = pc_q;
  assign IFID_Instruction = ifid_instr_q;
  assign IFID_PC_plus_4   = ifid_pc4_q;
  assign IFID_Valid       = ifid_valid_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed vector table, random run against a
// next-PC reference model, and an asynchronous reset taken during a stall.
module tb_if_fetch_stage;

  logic        clk, reset;
  logic [31:0] Instruction;
  logic        Stall, Branch_taken, Jump, JR;
  logic [31:0] Branch_target, JR_target;
  logic [25:0] Jump_index;
  logic [31:0] PC, IFID_Instruction, IFID_PC_plus_4;
  logic        IFID_Valid;

  int tests = 0;
  int errors = 0;

  if_fetch_stage #(.RESET_PC(32'h0), .NOP_WORD(32'h0)) dut (
    .clk(clk), .reset(reset), .Instruction(Instruction), .Stall(Stall),
    .Branch_taken(Branch_taken), .Branch_target(Branch_target),
    .Jump(Jump), .Jump_index(Jump_index), .JR(JR), .JR_target(JR_target),
    .PC(PC), .IFID_Instruction(IFID_Instruction),
    .IFID_PC_plus_4(IFID_PC_plus_4), .IFID_Valid(IFID_Valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction ROM stand-in; address 0 holds addi $4,$0,3.
  function automatic logic [31:0] rom(input logic [31:0] a);
    if (a == 32'h0) return 32'h20040003;
    return {a[15:0] ^ 16'hC3C3, a[15:0] | 16'h0001};
  endfunction

  assign Instruction = rom(PC);

  typedef struct packed {
    logic        st, br;
    logic [31:0] brt;
    logic        jp;
    logic [25:0] ji;
    logic        jr;
    logic [31:0] jrt;
    logic [31:0] pc, ins, pc4;
    logic        v;
  } vec_t;

  function automatic vec_t mk(input logic st, br, input logic [31:0] brt,
                              input logic jp, input logic [25:0] ji,
                              input logic jr, input logic [31:0] jrt,
                              input logic [31:0] pc, ins, pc4, input logic v);
    vec_t r;
    r.st = st; r.br = br; r.brt = brt; r.jp = jp; r.ji = ji;
    r.jr = jr; r.jrt = jrt; r.pc = pc; r.ins = ins; r.pc4 = pc4; r.v = v;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic st, br, input logic [31:0] brt,
                       input logic jp, input logic [25:0] ji,
                       input logic jr, input logic [31:0] jrt);
    Stall = st; Branch_taken = br; Branch_target = brt;
    Jump = jp; Jump_index = ji; JR = jr; JR_target = jrt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  vec_t vecs[22];
  logic [31:0] m_pc, m_ins, m_pc4;
  logic        m_v;

  initial begin
    vecs[0]  = mk(0,0,0,0,0,0,0, 32'h04, rom(32'h00), 32'h04, 1);
    vecs[1]  = mk(0,0,0,0,0,0,0, 32'h08, rom(32'h04), 32'h08, 1);
    vecs[2]  = mk(0,0,0,0,0,0,0, 32'h0C, rom(32'h08), 32'h0C, 1);
    vecs[3]  = mk(0,0,0,0,0,0,0, 32'h10, rom(32'h0C), 32'h10, 1);
    vecs[4]  = mk(0,0,0,0,0,0,0, 32'h14, rom(32'h10), 32'h14, 1);
    vecs[5]  = mk(1,0,0,0,0,0,0, 32'h14, rom(32'h10), 32'h14, 1);
    vecs[6]  = mk(1,0,0,0,0,0,0, 32'h14, rom(32'h10), 32'h14, 1);
    vecs[7]  = mk(0,0,0,0,0,0,0, 32'h18, rom(32'h14), 32'h18, 1);
    vecs[8]  = mk(0,0,0,0,0,0,0, 32'h1C, rom(32'h18), 32'h1C, 1);
    vecs[9]  = mk(0,0,0,0,0,0,0, 32'h20, rom(32'h1C), 32'h20, 1);
    vecs[10] = mk(0,0,0,0,0,0,0, 32'h24, rom(32'h20), 32'h24, 1);
    vecs[11] = mk(0,0,0,0,0,0,0, 32'h28, rom(32'h24), 32'h28, 1);
    vecs[12] = mk(0,0,0,1,26'hB,0,0, 32'h2C, 32'h0, 32'h0, 0);
    vecs[13] = mk(0,0,0,0,0,0,0, 32'h30, rom(32'h2C), 32'h30, 1);
    vecs[14] = mk(1,1,32'h20,1,26'h3F,0,0, 32'h20, 32'h0, 32'h0, 0);
    vecs[15] = mk(0,0,0,0,0,0,0, 32'h24, rom(32'h20), 32'h24, 1);
    vecs[16] = mk(0,0,0,0,0,1,32'h3C, 32'h3C, 32'h0, 32'h0, 0);
    vecs[17] = mk(0,0,0,1,26'h5,1,32'h100, 32'h100, 32'h0, 32'h0, 0);
    vecs[18] = mk(0,0,0,0,0,1,32'hFFFFFFFC, 32'hFFFFFFFC, 32'h0, 32'h0, 0);
    vecs[19] = mk(0,0,0,0,0,0,0, 32'h0, rom(32'hFFFFFFFC), 32'h0, 1);
    vecs[20] = mk(1,0,0,1,26'h7,0,0, 32'h0, rom(32'hFFFFFFFC), 32'h0, 1);
    vecs[21] = mk(0,0,0,0,0,0,0, 32'h4, rom(32'h0), 32'h4, 1);

    // Reset held for three cycles
    reset = 1'b0;
    drive(0,0,0,0,0,0,0);
    repeat (3) step();
    chk("rst_pc", PC, 32'h0);
    chk("rst_ins", IFID_Instruction, 32'h0);
    chk("rst_pc4", IFID_PC_plus_4, 32'h0);
    chk("rst_valid", {31'd0, IFID_Valid}, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Directed table
    for (int i = 0; i < 22; i++) begin
      drive(vecs[i].st, vecs[i].br, vecs[i].brt, vecs[i].jp, vecs[i].ji,
            vecs[i].jr, vecs[i].jrt);
      step();
      chk($sformatf("vec%0d_pc", i), PC, vecs[i].pc);
      chk($sformatf("vec%0d_valid", i), {31'd0, IFID_Valid}, {31'd0, vecs[i].v});
      chk($sformatf("vec%0d_ins", i), IFID_Instruction, vecs[i].ins);
      if (vecs[i].v) chk($sformatf("vec%0d_pc4", i), IFID_PC_plus_4, vecs[i].pc4);
    end
    chk("first_word", vecs[0].ins, 32'h20040003);

    // Random run against the reference model
    m_pc = 32'h4; m_ins = rom(32'h0); m_pc4 = 32'h4; m_v = 1'b1;
    for (int n = 0; n < 400; n++) begin
      logic st, br, jp, jr;
      logic [31:0] brt, jrt;
      logic [25:0] ji;
      st  = ($urandom % 5) == 0;
      br  = ($urandom % 8) == 0;
      jp  = m_v && (($urandom % 6) == 0);
      jr  = m_v && (($urandom % 8) == 0);
      brt = (($urandom % 4) == 0) ? 32'hFFFFFFF8 : {22'd0, 8'($urandom), 2'b00};
      jrt = (($urandom % 4) == 0) ? 32'hFFFFFFFC : {22'd0, 8'($urandom), 2'b00};
      ji  = 26'($urandom);
      drive(st, br, brt, jp, ji, jr, jrt);
      if (br) begin
        m_pc = brt; m_ins = 32'h0; m_v = 1'b0;
      end else if (st) begin
        m_pc = m_pc;
      end else if (jr) begin
        m_pc = jrt; m_ins = 32'h0; m_v = 1'b0;
      end else if (jp) begin
        m_pc = {m_pc4[31:28], ji, 2'b00}; m_ins = 32'h0; m_v = 1'b0;
      end else begin
        m_ins = rom(m_pc); m_pc4 = m_pc + 32'd4; m_pc = m_pc + 32'd4; m_v = 1'b1;
      end
      step();
      chk("rnd_pc", PC, m_pc);
      chk("rnd_valid", {31'd0, IFID_Valid}, {31'd0, m_v});
      chk("rnd_ins", IFID_Instruction, m_ins);
      if (m_v) chk("rnd_pc4", IFID_PC_plus_4, m_pc4);
    end

    // Asynchronous reset while stalled, between clock edges
    drive(0,0,0,0,0,1,32'h40);
    step();
    drive(0,0,0,0,0,0,0);
    step();
    drive(1,0,0,0,0,0,0);
    step();
    chk("pre_rst_pc", PC, 32'h44);
    #2;
    reset = 1'b0;
    #1;
    chk("async_pc", PC, 32'h0);
    chk("async_valid", {31'd0, IFID_Valid}, 32'h0);
    chk("async_ins", IFID_Instruction, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    drive(0,0,0,0,0,0,0);
    step();
    chk("post_rst_pc", PC, 32'h4);
    chk("post_rst_ins", IFID_Instruction, 32'h20040003);
    chk("post_rst_valid", {31'd0, IFID_Valid}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
